// File: rtl/adat_rx_smux_scheduler.sv
// ADAT receive-side S/MUX scheduler.
// Captures each decoded 8-slot frame, de-interleaves S/MUX2/S/MUX4 slot order
// and replays the samples as a time-ordered valid/ready beat stream.
// A second frame buffer absorbs downstream stalls. Frames that arrive while
// both buffers are occupied are dropped and counted.
module adat_rx_smux_scheduler #(
  parameter int DATA_W     = 24,
  parameter int DROP_CNT_W = 8
) (
  input  logic                        i_clk,
  input  logic                        i_rst,
  input  logic                        i_frame_valid,
  input  logic [7:0][DATA_W-1:0]      i_channels,
  input  logic [1:0]                  i_smux_mode,
  input  logic                        i_locked,
  output logic [DATA_W-1:0]           o_tdata,
  output logic [2:0]                  o_tchan,
  output logic [1:0]                  o_tphase,
  output logic                        o_tlast,
  output logic                        o_tvalid,
  input  logic                        i_tready,
  output logic                        o_busy,
  output logic                        o_overrun,
  output logic                        o_abort,
  output logic [DROP_CNT_W-1:0]       o_drop_count
);

  typedef enum logic {ST_IDLE, ST_EMIT} state_t;

  state_t                   r_state, w_state_nxt;
  logic [7:0][DATA_W-1:0]   r_act_data, r_pend_data;
  logic [1:0]               r_act_mode, r_pend_mode;
  logic                     r_pend_full;
  logic [2:0]               r_beat, w_beat_nxt;
  logic                     r_overrun, r_abort;
  logic [DROP_CNT_W-1:0]    r_drop_count;

  logic       w_busy, w_accept, w_flush, w_hs, w_last_hs;
  logic [1:0] w_in_mode;
  logic       w_load_act_in, w_load_act_pend, w_load_pend, w_clear_pend, w_drop;
  logic [2:0] w_slot;

  // Reserved mode 3 is folded to plain 8-channel mode when the frame is captured
  assign w_in_mode = (i_smux_mode == 2'd3) ? 2'd0 : i_smux_mode;
  assign w_busy    = (r_state == ST_EMIT) || r_pend_full;
  assign w_accept  = i_frame_valid && i_locked;
  assign w_flush   = w_busy && !i_locked;
  assign w_hs      = (r_state == ST_EMIT) && i_tready;
  assign w_last_hs = w_hs && (r_beat == 3'd7);

  // FSM state register
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_state <= ST_IDLE;
      r_beat  <= 3'd0;
    end else begin
      r_state <= w_state_nxt;
      r_beat  <= w_beat_nxt;
    end
  end

  // Next-state and buffer-control decisions; lock loss overrides everything
  always_comb begin
    w_state_nxt     = r_state;
    w_beat_nxt      = r_beat;
    w_load_act_in   = 1'b0;
    w_load_act_pend = 1'b0;
    w_load_pend     = 1'b0;
    w_clear_pend    = 1'b0;
    w_drop          = 1'b0;
    if (w_flush) begin
      w_state_nxt = ST_IDLE;
      w_beat_nxt  = 3'd0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (w_accept) begin
            w_load_act_in = 1'b1;
            w_beat_nxt    = 3'd0;
            w_state_nxt   = ST_EMIT;
          end
        end
        ST_EMIT: begin
          if (w_hs) w_beat_nxt = r_beat + 3'd1;
          if (w_last_hs) begin
            if (r_pend_full) begin
              w_load_act_pend = 1'b1;
              if (w_accept) w_load_pend  = 1'b1;
              else          w_clear_pend = 1'b1;
            end else if (w_accept) begin
              w_load_act_in = 1'b1;
            end else begin
              w_state_nxt = ST_IDLE;
            end
          end else if (w_accept) begin
            if (r_pend_full) w_drop      = 1'b1;
            else             w_load_pend = 1'b1;
          end
        end
        default: w_state_nxt = ST_IDLE;
      endcase
    end
  end

  // Frame buffers, event pulses and the saturating drop counter
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_act_data   <= '0;
      r_act_mode   <= 2'd0;
      r_pend_data  <= '0;
      r_pend_mode  <= 2'd0;
      r_pend_full  <= 1'b0;
      r_overrun    <= 1'b0;
      r_abort      <= 1'b0;
      r_drop_count <= '0;
    end else begin
      r_overrun <= w_drop;
      r_abort   <= w_flush;
      if (w_flush) begin
        r_act_data  <= '0;
        r_act_mode  <= 2'd0;
        r_pend_data <= '0;
        r_pend_mode <= 2'd0;
        r_pend_full <= 1'b0;
      end else begin
        if (w_load_act_in) begin
          r_act_data <= i_channels;
          r_act_mode <= w_in_mode;
        end else if (w_load_act_pend) begin
          r_act_data <= r_pend_data;
          r_act_mode <= r_pend_mode;
        end
        if (w_load_pend) begin
          r_pend_data <= i_channels;
          r_pend_mode <= w_in_mode;
          r_pend_full <= 1'b1;
        end else if (w_clear_pend) begin
          r_pend_full <= 1'b0;
        end
      end
      if (w_drop && (r_drop_count != {DROP_CNT_W{1'b1}}))
        r_drop_count <= r_drop_count + DROP_CNT_W'(1);
    end
  end

  // Beat-to-slot de-interleave; outputs are held at zero while no beat is offered
  always_comb begin
    w_slot   = r_beat;
    o_tchan  = 3'd0;
    o_tphase = 2'd0;
    o_tlast  = 1'b0;
    o_tdata  = '0;
    case (r_act_mode)
      2'd1: begin
        w_slot   = {r_beat[1:0], r_beat[2]};
        o_tchan  = {1'b0, r_beat[1:0]};
        o_tphase = {1'b0, r_beat[2]};
        o_tlast  = (r_beat[1:0] == 2'd3);
      end
      2'd2: begin
        w_slot   = {r_beat[0], r_beat[2:1]};
        o_tchan  = {2'b00, r_beat[0]};
        o_tphase = r_beat[2:1];
        o_tlast  = r_beat[0];
      end
      default: begin
        w_slot   = r_beat;
        o_tchan  = r_beat;
        o_tphase = 2'd0;
        o_tlast  = (r_beat == 3'd7);
      end
    endcase
    o_tdata = r_act_data[w_slot];
    if (r_state != ST_EMIT) begin
      o_tchan  = 3'd0;
      o_tphase = 2'd0;
      o_tlast  = 1'b0;
      o_tdata  = '0;
    end
  end

  assign o_tvalid     = (r_state == ST_EMIT);
  assign o_busy       = w_busy;
  assign o_overrun    = r_overrun;
  assign o_abort      = r_abort;
  assign o_drop_count = r_drop_count;

endmodule

// File: tb/tb_adat_rx_smux_scheduler.sv
// Testbench for adat_rx_smux_scheduler.
// A queue of expected beats is built per accepted frame from the logical
// channel/period layout of each S/MUX mode, and every cycle the DUT is
// compared against the head of that queue and against the expected
// busy/overrun/abort/drop-count status.
module tb_adat_rx_smux_scheduler;

  localparam int DATA_W = 24;
  localparam int DCW    = 8;

  logic                   clk = 1'b0;
  logic                   rst = 1'b1;
  logic                   fv = 1'b0;
  logic                   locked = 1'b0;
  logic                   tready = 1'b0;
  logic [1:0]             mode = 2'd0;
  logic [7:0][DATA_W-1:0] chans = '0;

  logic [DATA_W-1:0] tdata;
  logic [2:0]        tchan;
  logic [1:0]        tphase;
  logic              tlast, tvalid, busy, overrun, abortPulse;
  logic [DCW-1:0]    dropCount;

  typedef struct {
    logic [DATA_W-1:0] data;
    logic [2:0]        chan;
    logic [1:0]        phase;
    logic              last;
  } beat_t;

  beat_t expQ[$];
  logic  expAbort = 1'b0;
  logic  expOverrun = 1'b0;
  int    expDrop = 0;
  int    checks = 0;
  int    errors = 0;

  adat_rx_smux_scheduler #(.DATA_W(DATA_W), .DROP_CNT_W(DCW)) dut (
    .i_clk(clk), .i_rst(rst), .i_frame_valid(fv), .i_channels(chans),
    .i_smux_mode(mode), .i_locked(locked), .o_tdata(tdata), .o_tchan(tchan),
    .o_tphase(tphase), .o_tlast(tlast), .o_tvalid(tvalid), .i_tready(tready),
    .o_busy(busy), .o_overrun(overrun), .o_abort(abortPulse),
    .o_drop_count(dropCount)
  );

  // Free-running 100 MHz clock
  always #5 clk = ~clk;

  // Count one comparison and report it if it disagrees
  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Expected beats of one frame: sample periods in order, channels within each period
  task automatic pushFrame(input logic [7:0][DATA_W-1:0] ch, input logic [1:0] m);
    int nch, nph;
    beat_t b;
    nch = (m == 2'd1) ? 4 : (m == 2'd2) ? 2 : 8;
    nph = 8 / nch;
    for (int ph = 0; ph < nph; ph++) begin
      for (int c = 0; c < nch; c++) begin
        b.data  = ch[c * nph + ph];
        b.chan  = 3'(c);
        b.phase = 2'(ph);
        b.last  = (c == nch - 1);
        expQ.push_back(b);
      end
    end
  endtask

  // Drive one cycle of inputs, check outputs mid-cycle, then advance the model
  task automatic applyStimulus(input logic f, input logic l, input logic r,
                               input logic [1:0] m, input logic [7:0][DATA_W-1:0] ch);
    fv = f; locked = l; tready = r; mode = m; chans = ch;
    @(negedge clk);
    checkOutput("tvalid", 32'(tvalid), 32'(expQ.size() > 0));
    if (expQ.size() > 0) begin
      checkOutput("tdata", 32'(tdata), 32'(expQ[0].data));
      checkOutput("tchan", 32'(tchan), 32'(expQ[0].chan));
      checkOutput("tphase", 32'(tphase), 32'(expQ[0].phase));
      checkOutput("tlast", 32'(tlast), 32'(expQ[0].last));
    end
    checkOutput("busy", 32'(busy), 32'(expQ.size() > 0));
    checkOutput("abort", 32'(abortPulse), 32'(expAbort));
    checkOutput("overrun", 32'(overrun), 32'(expOverrun));
    checkOutput("drop_count", 32'(dropCount), 32'(expDrop));
    expAbort = 1'b0;
    expOverrun = 1'b0;
    if (expQ.size() > 0 && !l) begin
      expQ.delete();
      expAbort = 1'b1;
    end else begin
      if (expQ.size() > 0 && r) expQ.delete(0);
      if (f && l) begin
        if (expQ.size() > 8) begin
          expOverrun = 1'b1;
          if (expDrop < 255) expDrop++;
        end else begin
          pushFrame(ch, m);
        end
      end
    end
    @(posedge clk);
    #1;
  endtask

  function automatic logic [7:0][DATA_W-1:0] randFrame();
    logic [7:0][DATA_W-1:0] f;
    for (int i = 0; i < 8; i++) f[i] = DATA_W'($urandom);
    return f;
  endfunction

  logic [7:0][DATA_W-1:0] f0, f1, f2;

  // Directed scenarios followed by a randomized soak
  initial begin
    f0 = {24'hABCDEF, 24'h567890, 24'hF01234, 24'h9ABCDE,
          24'h345678, 24'hDEF012, 24'h789ABC, 24'h123456};
    f1 = {24'hDD1111, 24'hDD0000, 24'hCC1111, 24'hCC0000,
          24'hBB1111, 24'hBB0000, 24'hAA1111, 24'hAA0000};
    for (int i = 0; i < 8; i++) f2[i] = DATA_W'(i * 24'h111111);

    repeat (3) @(posedge clk);
    #1;
    checkOutput("rst_tvalid", 32'(tvalid), 0);
    checkOutput("rst_busy", 32'(busy), 0);
    checkOutput("rst_drop", 32'(dropCount), 0);
    checkOutput("rst_tdata", 32'(tdata), 0);
    rst = 1'b0;

    $display("[TB] mode0/mode1/mode2 single frames");
    applyStimulus(1'b1, 1'b1, 1'b1, 2'd0, f0);
    repeat (10) applyStimulus(1'b0, 1'b1, 1'b1, 2'd0, f0);
    applyStimulus(1'b1, 1'b1, 1'b1, 2'd1, f1);
    repeat (10) applyStimulus(1'b0, 1'b1, 1'b1, 2'd0, f0);
    applyStimulus(1'b1, 1'b1, 1'b1, 2'd2, f2);
    repeat (10) applyStimulus(1'b0, 1'b1, 1'b1, 2'd0, f0);

    $display("[TB] stall with three frames");
    for (int c = 0; c < 20; c++)
      applyStimulus(c == 0 || c == 5 || c == 10, 1'b1, 1'b0, 2'd0, randFrame());
    checkOutput("stall_drop", 32'(dropCount), 1);
    repeat (20) applyStimulus(1'b0, 1'b1, 1'b1, 2'd0, f0);

    $display("[TB] lock loss mid-frame");
    applyStimulus(1'b1, 1'b1, 1'b1, 2'd0, f0);
    repeat (3) applyStimulus(1'b0, 1'b1, 1'b1, 2'd0, f0);
    applyStimulus(1'b0, 1'b0, 1'b1, 2'd0, f0);
    applyStimulus(1'b0, 1'b0, 1'b1, 2'd0, f0);
    applyStimulus(1'b1, 1'b1, 1'b1, 2'd1, f1);
    repeat (10) applyStimulus(1'b0, 1'b1, 1'b1, 2'd0, f0);

    $display("[TB] drop counter saturation");
    repeat (262) applyStimulus(1'b1, 1'b1, 1'b0, 2'($urandom_range(0, 3)), randFrame());
    checkOutput("sat_drop", 32'(dropCount), 255);
    repeat (20) applyStimulus(1'b0, 1'b1, 1'b1, 2'd0, f0);

    $display("[TB] randomized traffic");
    for (int c = 0; c < 3000; c++)
      applyStimulus($urandom_range(0, 5) == 0, $urandom_range(0, 149) != 0,
                    $urandom_range(0, 9) < 7, 2'($urandom_range(0, 3)), randFrame());
    repeat (20) applyStimulus(1'b0, 1'b1, 1'b1, 2'd0, f0);

    $display("[TB] asynchronous reset mid-frame");
    applyStimulus(1'b1, 1'b1, 1'b1, 2'd0, f0);
    repeat (3) applyStimulus(1'b0, 1'b1, 1'b0, 2'd0, f0);
    #2;
    rst = 1'b1;
    #1;
    checkOutput("arst_tvalid", 32'(tvalid), 0);
    checkOutput("arst_tdata", 32'(tdata), 0);
    checkOutput("arst_busy", 32'(busy), 0);
    checkOutput("arst_drop", 32'(dropCount), 0);
    expQ.delete();
    expDrop = 0;
    expAbort = 1'b0;
    expOverrun = 1'b0;
    @(posedge clk);
    #1;
    rst = 1'b0;
    applyStimulus(1'b1, 1'b0, 1'b1, 2'd0, f0);
    repeat (5) applyStimulus(1'b0, 1'b0, 1'b1, 2'd0, f0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
